// File: rtl/am29xx_pkg.sv
// Shared encodings for the Am2901/Am2904 sequencing blocks: FSM states and
// the fixed Am2904 I-field sub-codes driven during shift passes.
package am29xx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } shseq_state_e;

    localparam logic [1:0] CIN_ZERO      = 2'b00;
    localparam logic [1:0] SRC_MSR       = 2'b10;
    localparam logic [4:0] SH_UP_DBL_LNK = 5'b10100;

endpackage

// File: rtl/am2904_shseq.sv
// Multi-cycle shift sequencer for an Am2904 and its Am2901 slices: runs one
// latched shift command for N cycles, optionally stopping early on CT.
module am2904_shseq
    import am29xx_pkg::*;
#(
    parameter int CNTW = 5
) (
    input  logic            cp,
    input  logic            rst_,
    input  logic            start,
    input  logic            abort,
    input  logic [4:0]      cmd_sh,
    input  logic [CNTW-1:0] cmd_cnt,
    input  logic            cmd_norm,
    input  logic [3:0]      cmd_cond,
    input  logic            ct,
    output logic [12:0]     i,
    output logic            se_,
    output logic            cem_,
    output logic            ceu_,
    output logic            oect_,
    output logic            alu_en,
    output logic            busy,
    output logic            done,
    output logic [CNTW-1:0] cnt_out
);

    shseq_state_e    state_q, state_d;
    logic [4:0]      sh_q, sh_d;
    logic [3:0]      cond_q, cond_d;
    logic            norm_q, norm_d;
    logic [CNTW-1:0] rem_q, rem_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic        shift_now;
    logic        ct_hit;
    logic [12:0] run_i;

    // ct only matters in normalize mode; abort overrides both ct and the shift
    assign ct_hit    = norm_q & ct;
    assign shift_now = (state_q == ST_RUN) & ~abort & ~ct_hit;
    assign run_i     = {CIN_ZERO, sh_q, SRC_MSR, cond_q};

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cond_d  = cond_q;
        norm_d  = norm_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sh_d    = cmd_sh;
                    cond_d  = cmd_cond;
                    norm_d  = cmd_norm;
                    rem_d   = cmd_cnt;
                    cnt_d   = '0;
                    state_d = (cmd_cnt == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (shift_now) begin
                    rem_d = rem_q - CNTW'(1);
                    cnt_d = cnt_q + CNTW'(1);
                end
                if (abort || ct_hit || (shift_now && rem_q == CNTW'(1)))
                    state_d = ST_FIN;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge cp or negedge rst_) begin
        if (!rst_) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            cond_q  <= '0;
            norm_q  <= 1'b0;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cond_q  <= cond_d;
            norm_q  <= norm_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        i      = '0;
        se_    = 1'b1;
        cem_   = 1'b1;
        ceu_   = 1'b1;
        oect_  = 1'b1;
        alu_en = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (state_q)
            ST_RUN: begin
                i      = run_i;
                se_    = ~shift_now;
                oect_  = ~norm_q;
                alu_en = shift_now;
                busy   = 1'b1;
            end
            ST_FIN: begin
                i    = run_i;
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign cnt_out = cnt_q;

endmodule

// File: tb/tb_am2904_shseq.sv
// Bench for am2904_shseq: a byte register stands in for the slices (shifts
// left on alu_en) and CT is its MSB xor the polarity bit of the condition.
module tb_am2904_shseq;
    import am29xx_pkg::*;

    localparam int CNTW = 5;

    logic            cp = 1'b0;
    logic            rst_ = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [4:0]      cmd_sh = '0;
    logic [CNTW-1:0] cmd_cnt = '0;
    logic            cmd_norm = 1'b0;
    logic [3:0]      cmd_cond = '0;
    logic            ct;
    logic [12:0]     i;
    logic            se_, cem_, ceu_, oect_, alu_en, busy, done;
    logic [CNTW-1:0] cnt_out;

    logic [7:0] data = '0;
    logic [7:0] load_val = '0;
    logic       load = 1'b0;

    int nvec = 0;
    int nerr = 0;

    am2904_shseq #(.CNTW(CNTW)) dut (
        .cp(cp), .rst_(rst_), .start(start), .abort(abort),
        .cmd_sh(cmd_sh), .cmd_cnt(cmd_cnt), .cmd_norm(cmd_norm), .cmd_cond(cmd_cond),
        .ct(ct), .i(i), .se_(se_), .cem_(cem_), .ceu_(ceu_), .oect_(oect_),
        .alu_en(alu_en), .busy(busy), .done(done), .cnt_out(cnt_out)
    );

    always #5 cp = ~cp;

    always @(posedge cp) begin
        if (load) data <= load_val;
        else if (alu_en) data <= {data[6:0], 1'b0};
    end

    assign ct = data[7] ^ cmd_cond[0];

    typedef struct {
        logic [4:0] sh;
        int         n;
        logic       nrm;
        logic [3:0] cond;
        logic [7:0] d0;
        int         ab_at;
        logic       ab_start;
        logic       st_noise;
        int         exp_sh;
        int         exp_r;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Command-level reference: the run ends at the first stop event (abort or
    // CT reaching 1 after leading-zero shifts) or after N shifts.
    task automatic model(input int n, input logic nrm, input logic [7:0] d0, input int ab_at,
                         output int shifts, output int runs);
        int lz;
        int s;
        lz = 1000;
        for (int b = 7; b >= 0; b--) begin
            if (d0[b] && lz == 1000) lz = 7 - b;
        end
        s = 1000;
        if (nrm) s = lz + 1;
        if (ab_at != 0 && ab_at < s) s = ab_at;
        if (n == 0) begin
            shifts = 0; runs = 0;
        end else if (s - 1 < n) begin
            shifts = s - 1; runs = s;
        end else begin
            shifts = n; runs = n;
        end
    endtask

    task automatic run_cmd(input vec_t v);
        logic [12:0] ei;
        logic [19:0] ev, av;
        logic [7:0]  exp_data;
        logic        er, ef, es;
        ei = {2'b00, v.sh, 2'b10, v.cond};
        exp_data = v.d0 << v.exp_sh;
        @(negedge cp);
        cmd_sh = v.sh; cmd_cnt = CNTW'(v.n); cmd_norm = v.nrm; cmd_cond = v.cond;
        load_val = v.d0; load = 1'b1;
        start = 1'b1; abort = v.ab_start;
        @(posedge cp); #1;
        load = 1'b0;
        start = v.st_noise;
        abort = (v.ab_at == 1);
        for (int j = 1; j <= v.exp_r + 3; j++) begin
            @(negedge cp);
            er = (j <= v.exp_r);
            ef = (j == v.exp_r + 1);
            es = (j <= v.exp_sh);
            ev = {(er || ef) ? ei : 13'd0, ~es, 1'b1, 1'b1, ~(v.nrm && er), es, er || ef, ef};
            av = {i, se_, cem_, ceu_, oect_, alu_en, busy, done};
            chk($sformatf("cycle%0d{i,se_,cem_,ceu_,oect_,alu_en,busy,done}", j), 32'(av), 32'(ev));
            @(posedge cp); #1;
            abort = (v.ab_at == j + 1);
            start = v.st_noise && (j + 1 <= v.exp_r + 1);
        end
        abort = 1'b0;
        start = 1'b0;
        chk("cnt_out", 32'(cnt_out), 32'(v.exp_sh));
        chk("data", 32'(data), 32'(exp_data));
    endtask

    vec_t tbl[10];
    vec_t rv;

    initial begin
        tbl[0] = '{SH_UP_DBL_LNK, 3,  1'b0, 4'h0, 8'h01, 0, 1'b0, 1'b0, 3,  3};
        tbl[1] = '{SH_UP_DBL_LNK, 0,  1'b0, 4'h0, 8'h01, 0, 1'b0, 1'b0, 0,  0};
        tbl[2] = '{SH_UP_DBL_LNK, 7,  1'b1, 4'h4, 8'h10, 0, 1'b0, 1'b0, 3,  4};
        tbl[3] = '{SH_UP_DBL_LNK, 5,  1'b1, 4'h4, 8'h90, 0, 1'b0, 1'b0, 0,  1};
        tbl[4] = '{SH_UP_DBL_LNK, 5,  1'b0, 4'h0, 8'h01, 3, 1'b0, 1'b1, 2,  3};
        tbl[5] = '{5'b00110,      4,  1'b0, 4'h2, 8'h03, 0, 1'b1, 1'b0, 4,  4};
        tbl[6] = '{SH_UP_DBL_LNK, 4,  1'b1, 4'h4, 8'h01, 0, 1'b0, 1'b0, 4,  4};
        tbl[7] = '{SH_UP_DBL_LNK, 1,  1'b0, 4'h0, 8'h05, 0, 1'b0, 1'b1, 1,  1};
        tbl[8] = '{SH_UP_DBL_LNK, 31, 1'b0, 4'h0, 8'h01, 0, 1'b0, 1'b0, 31, 31};
        tbl[9] = '{SH_UP_DBL_LNK, 1,  1'b1, 4'h4, 8'h40, 0, 1'b0, 1'b0, 1,  1};

        #12;
        chk("reset{i,se_,cem_,ceu_,oect_,alu_en,busy,done}",
            32'({i, se_, cem_, ceu_, oect_, alu_en, busy, done}), 32'({13'd0, 7'b1111000}));
        chk("reset cnt_out", 32'(cnt_out), 32'd0);
        @(negedge cp);
        rst_ = 1'b1;

        foreach (tbl[k]) run_cmd(tbl[k]);

        // reset in the middle of a 6-shift command
        @(negedge cp);
        cmd_sh = SH_UP_DBL_LNK; cmd_cnt = CNTW'(6); cmd_norm = 1'b0; cmd_cond = 4'h0;
        start = 1'b1;
        @(posedge cp); #1 start = 1'b0;
        @(negedge cp);
        @(negedge cp);
        #2 rst_ = 1'b0;
        #1;
        chk("async rst se_", 32'(se_), 32'd1);
        chk("async rst busy", 32'(busy), 32'd0);
        chk("async rst cnt_out", 32'(cnt_out), 32'd0);
        @(negedge cp);
        rst_ = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge cp);
            chk("post-reset {busy,done}", 32'({busy, done}), 32'd0);
        end
        run_cmd(tbl[0]);

        for (int r = 0; r < 60; r++) begin
            rv.sh       = 5'($urandom);
            rv.n        = $urandom_range(0, 12);
            rv.nrm      = 1'($urandom);
            rv.cond     = {3'($urandom), 1'b0};
            rv.d0       = 8'($urandom);
            rv.ab_at    = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 14) : 0;
            rv.ab_start = 1'($urandom);
            rv.st_noise = 1'($urandom);
            model(rv.n, rv.nrm, rv.d0, rv.ab_at, rv.exp_sh, rv.exp_r);
            run_cmd(rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
